// File: rtl/uart_byte_tx.sv
// 8N1 UART transmitter (optional even parity) with a one-byte holding buffer
// and a wrapping count of completed frames.
module uart_byte_tx #(
  parameter int CLK_DIV   = 16,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       tx,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  localparam int TW = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
  localparam logic [TW-1:0] RELOAD = TW'(CLK_DIV - 1);

  if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
    $error("uart_byte_tx: CLK_DIV must be in 2..65535");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shifter;
  logic [7:0]    hold;
  logic          hold_full;
  logic          par;

  // Handshake: a byte is taken on any edge where s_valid && s_ready; s_ready
  // is the inverse of the registered hold_full flag, so it never depends on
  // s_valid, and s_valid may drop at any time while s_ready is low.
  assign s_ready = ~hold_full;
  assign busy    = (state != IDLE) || hold_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      shifter   <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      par       <= 1'b0;
      tx        <= 1'b1;
      frame_cnt <= '0;
    end else begin
      // Accept and load never coincide: accept needs hold_full=0, load needs 1.
      if (s_valid && !hold_full) begin
        hold      <= s_data;
        hold_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (hold_full) begin
            shifter   <= hold;
            par       <= ^hold;
            hold_full <= 1'b0;
            tx        <= 1'b0;
            timer     <= RELOAD;
            state     <= START;
          end
        end

        START, DATA, PARITY, STOP: begin
          if (timer != '0) begin
            timer <= timer - TW'(1);
          end else begin
            timer <= RELOAD;
            case (state)
              START: begin
                tx      <= shifter[0];
                shifter <= {1'b0, shifter[7:1]};
                bit_idx <= '0;
                state   <= DATA;
              end
              DATA: begin
                if (bit_idx == 3'd7) begin
                  if (PARITY_EN) begin
                    tx    <= par;
                    state <= PARITY;
                  end else begin
                    tx    <= 1'b1;
                    state <= STOP;
                  end
                end else begin
                  tx      <= shifter[0];
                  shifter <= {1'b0, shifter[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                end
              end
              PARITY: begin
                tx    <= 1'b1;
                state <= STOP;
              end
              default: begin
                // End of stop bit: count the frame, then chain straight into
                // the next start bit when a byte is waiting.
                frame_cnt <= frame_cnt + 8'd1;
                if (hold_full) begin
                  shifter   <= hold;
                  par       <= ^hold;
                  hold_full <= 1'b0;
                  tx        <= 1'b0;
                  state     <= START;
                end else begin
                  timer <= '0;
                  state <= IDLE;
                end
              end
            endcase
          end
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
